// File: rtl/core_pkg.sv
// Shared definitions for the fetch path: sequencer states and the default boot address.
package core_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// Loads a program into instruction memory, then fetches sequentially with redirect and
// fault detection. The memory itself lives beside this block.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int unsigned WORDS    = 64,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault
);

  localparam int unsigned CntW = $clog2(WORDS) + 1;

  fetch_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic          load_end;
  logic          advance;
  logic          pc_oob;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    // Loading stops at whichever comes first: the marked last word or a full memory.
    load_end   = load_last || (cnt_q == CntW'(WORDS - 1));
    advance    = !if_valid_q || if_ready;
    pc_oob     = {2'b00, pc_q[31:2]} >= WORDS;

    unique case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = 32'(cnt_q);
          mem_wdata = load_data;
          cnt_d     = cnt_q + CntW'(1);
          if (load_end) begin
            state_d = RUN;
            pc_d    = RESET_PC;
          end
        end
      end
      RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
          else                           pc_d    = redirect_pc;
        end else if (advance) begin
          if (pc_oob) begin
            state_d    = FAULT;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = mem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      FAULT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign mem_raddr = {2'b00, pc_q[31:2]};
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 64-word instance and a 4-word instance.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset_n, a_load_valid, a_load_last, a_load_ready, a_mem_we;
  logic [31:0] a_load_data, a_mem_waddr, a_mem_wdata, a_mem_raddr, a_mem_rdata;
  logic        a_redirect_valid, a_if_ready, a_if_valid, a_fault;
  logic [31:0] a_redirect_pc, a_if_instr, a_if_pc;

  logic        b_reset_n, b_load_valid, b_load_last, b_load_ready, b_mem_we;
  logic [31:0] b_load_data, b_mem_waddr, b_mem_wdata, b_mem_raddr, b_mem_rdata;
  logic        b_redirect_valid, b_if_ready, b_if_valid, b_fault;
  logic [31:0] b_redirect_pc, b_if_instr, b_if_pc;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [4];

  pair_t wq_a[$], fq_a[$], wq_b[$], fq_b[$];
  pair_t e;
  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.WORDS(64)) dut_a (
    .clk(clk), .reset_n(a_reset_n),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_last(a_load_last),
    .load_ready(a_load_ready),
    .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata),
    .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .if_ready(a_if_ready), .if_valid(a_if_valid), .if_instr(a_if_instr), .if_pc(a_if_pc),
    .fault(a_fault)
  );

  fetch_sequencer #(.WORDS(4)) dut_b (
    .clk(clk), .reset_n(b_reset_n),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
    .load_ready(b_load_ready),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
    .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .if_ready(b_if_ready), .if_valid(b_if_valid), .if_instr(b_if_instr), .if_pc(b_if_pc),
    .fault(b_fault)
  );

  always @(posedge clk) begin
    if (a_mem_we && a_mem_waddr < 32'd64) mem_a[a_mem_waddr[5:0]] <= a_mem_wdata;
    if (b_mem_we && b_mem_waddr < 32'd4)  mem_b[b_mem_waddr[1:0]] <= b_mem_wdata;
  end

  assign a_mem_rdata = (a_mem_raddr < 32'd64) ? mem_a[a_mem_raddr[5:0]] : 32'h0;
  assign b_mem_rdata = (b_mem_raddr < 32'd4)  ? mem_b[b_mem_raddr[1:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset_n = 0; a_load_valid = 0; a_load_data = 0; a_load_last = 0;
    a_redirect_valid = 0; a_redirect_pc = 0; a_if_ready = 0;
    b_reset_n = 0; b_load_valid = 0; b_load_data = 0; b_load_last = 0;
    b_redirect_valid = 0; b_redirect_pc = 0; b_if_ready = 0;

    // Monitor: every presented write or fetch handshake is checked against the queues.
    fork
      forever begin
        @(negedge clk);
        if (a_mem_we) begin
          if (wq_a.size() == 0) chk("a_unexpected_write", a_mem_waddr, 32'hFFFF_FFFF);
          else begin
            e = wq_a.pop_front();
            chk("a_waddr", a_mem_waddr, e.a);
            chk("a_wdata", a_mem_wdata, e.d);
          end
        end
        if (a_if_valid && a_if_ready) begin
          if (fq_a.size() == 0) chk("a_unexpected_fetch", a_if_pc, 32'hFFFF_FFFF);
          else begin
            e = fq_a.pop_front();
            chk("a_if_pc", a_if_pc, e.a);
            chk("a_if_instr", a_if_instr, e.d);
          end
        end
        if (b_mem_we) begin
          if (wq_b.size() == 0) chk("b_unexpected_write", b_mem_waddr, 32'hFFFF_FFFF);
          else begin
            e = wq_b.pop_front();
            chk("b_waddr", b_mem_waddr, e.a);
            chk("b_wdata", b_mem_wdata, e.d);
          end
        end
        if (b_if_valid && b_if_ready) begin
          if (fq_b.size() == 0) chk("b_unexpected_fetch", b_if_pc, 32'hFFFF_FFFF);
          else begin
            e = fq_b.pop_front();
            chk("b_if_pc", b_if_pc, e.a);
            chk("b_if_instr", b_if_instr, e.d);
          end
        end
      end
    join_none

    step();
    step();
    @(negedge clk);
    chk("rst_load_ready", 32'(a_load_ready), 32'd1);
    chk("rst_if_valid", 32'(a_if_valid), 32'd0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_if_pc", a_if_pc, 32'd0);
    chk("rst_if_instr", a_if_instr, 32'd0);
    chk("rst_mem_raddr", a_mem_raddr, 32'd0);

    // Reset during the second load word restarts the count at zero.
    step();
    a_reset_n = 1; a_load_valid = 1; a_load_data = 32'hDEAD_0001;
    wq_a.push_back('{32'd0, 32'hDEAD_0001});
    step();
    a_reset_n = 0; a_load_data = 32'hDEAD_0002;
    wq_a.push_back('{32'd1, 32'hDEAD_0002});
    step();
    a_reset_n = 1; a_load_data = 32'h0000_0013;
    wq_a.push_back('{32'd0, 32'h0000_0013});
    step();
    a_load_data = 32'h0010_0093;
    wq_a.push_back('{32'd1, 32'h0010_0093});
    step();
    a_load_data = 32'h0020_0113; a_load_last = 1;
    wq_a.push_back('{32'd2, 32'h0020_0113});
    step();
    a_load_valid = 0; a_load_last = 0;
    @(negedge clk);
    chk("run_entry_if_valid", 32'(a_if_valid), 32'd0);
    chk("run_entry_load_ready", 32'(a_load_ready), 32'd0);
    chk("run_entry_raddr", a_mem_raddr, 32'd0);
    fq_a.push_back('{32'd0, 32'h0000_0013});
    fq_a.push_back('{32'd4, 32'h0010_0093});
    fq_a.push_back('{32'd8, 32'h0020_0113});

    step();
    @(negedge clk);
    chk("first_if_valid", 32'(a_if_valid), 32'd1);
    chk("first_if_pc", a_if_pc, 32'd0);
    chk("first_if_instr", a_if_instr, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("stall_if_pc", a_if_pc, 32'd0);
      chk("stall_raddr", a_mem_raddr, 32'd1);
      chk("stall_if_valid", 32'(a_if_valid), 32'd1);
    end
    step();
    a_if_ready = 1;
    step();
    step();
    step();
    a_if_ready = 0; a_redirect_valid = 1; a_redirect_pc = 32'h8;
    @(negedge clk);
    chk("pre_redirect_valid", 32'(a_if_valid), 32'd1);
    chk("pre_redirect_pc", a_if_pc, 32'd12);

    step();
    a_redirect_valid = 0; a_if_ready = 1;
    fq_a.push_back('{32'd8, 32'h0020_0113});
    @(negedge clk);
    chk("redirect_if_valid", 32'(a_if_valid), 32'd0);
    chk("redirect_raddr", a_mem_raddr, 32'd2);
    step();
    @(negedge clk);
    chk("redirect_target_pc", a_if_pc, 32'd8);

    step();
    a_if_ready = 0; a_redirect_valid = 1; a_redirect_pc = 32'h6;
    step();
    a_redirect_valid = 0; a_load_valid = 1; a_load_data = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("fault_set", 32'(a_fault), 32'd1);
    chk("fault_if_valid", 32'(a_if_valid), 32'd0);
    chk("fault_load_ready", 32'(a_load_ready), 32'd0);
    chk("fault_mem_we", 32'(a_mem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      a_redirect_valid = 1; a_redirect_pc = 32'h0; a_if_ready = 1;
      @(negedge clk);
      chk("fault_sticky", 32'(a_fault), 32'd1);
      chk("fault_no_fetch", 32'(a_if_valid), 32'd0);
    end
    step();
    a_reset_n = 0; a_redirect_valid = 0; a_load_valid = 0; a_if_ready = 0;
    step();
    a_reset_n = 1;
    @(negedge clk);
    chk("fault_cleared", 32'(a_fault), 32'd0);
    chk("reload_ready", 32'(a_load_ready), 32'd1);
    chk("reload_if_valid", 32'(a_if_valid), 32'd0);

    // Four-word instance: overlong load truncates, then fetch runs off the end.
    step();
    b_reset_n = 1; b_if_ready = 1; b_load_valid = 1; b_load_data = 32'hB000_0000;
    wq_b.push_back('{32'd0, 32'hB000_0000});
    step();
    b_load_data = 32'hB000_0001;
    wq_b.push_back('{32'd1, 32'hB000_0001});
    step();
    b_load_data = 32'hB000_0002;
    wq_b.push_back('{32'd2, 32'hB000_0002});
    step();
    b_load_data = 32'hB000_0003;
    wq_b.push_back('{32'd3, 32'hB000_0003});
    step();
    b_load_data = 32'hB000_0004;
    @(negedge clk);
    chk("b_fifth_load_ready", 32'(b_load_ready), 32'd0);
    chk("b_fifth_mem_we", 32'(b_mem_we), 32'd0);
    fq_b.push_back('{32'd0, 32'hB000_0000});
    fq_b.push_back('{32'd4, 32'hB000_0001});
    fq_b.push_back('{32'd8, 32'hB000_0002});
    fq_b.push_back('{32'd12, 32'hB000_0003});
    step();
    b_load_valid = 0;
    for (int i = 0; i < 12 && !b_fault; i++) begin
      step();
      @(negedge clk);
    end
    chk("b_oob_fault", 32'(b_fault), 32'd1);
    chk("b_oob_if_valid", 32'(b_if_valid), 32'd0);

    step();
    @(negedge clk);
    chk("a_writes_drained", 32'(wq_a.size()), 32'd0);
    chk("a_fetches_drained", 32'(fq_a.size()), 32'd0);
    chk("b_writes_drained", 32'(wq_b.size()), 32'd0);
    chk("b_fetches_drained", 32'(fq_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WORDS, default 64: instruction memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch byte address after load.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 load_valid  input  1  loader word available.
REQ-006 load_data  input  32  instruction word to store.
REQ-007 load_last  input  1  current load word is final program word.
REQ-008 load_ready  output  1  block accepts load word this cycle.
REQ-009 mem_we  output  1  memory write strobe.
REQ-010 mem_waddr  output  32  memory word index for write.
REQ-011 mem_wdata  output  32  memory write data.
REQ-012 mem_raddr  output  32  memory word index for read; read data is combinational.
REQ-013 mem_rdata  input  32  instruction at mem_raddr.
REQ-014 redirect_valid  input  1  core requests PC change (branch/jump).
REQ-015 redirect_pc  input  32  target byte address.
REQ-016 if_ready  input  1  decode stage accepts if_instr.
REQ-017 if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-018 if_instr  output  32  fetched instruction.
REQ-019 if_pc  output  32  byte address of if_instr.
REQ-020 fault  output  1  sticky fetch fault flag.

Function
REQ-021 The FSM SHALL have states LOAD, RUN and FAULT; reset enters LOAD.
REQ-022 In LOAD: load_ready=1; on load_valid SHALL drive mem_we=1, mem_waddr=load count, mem_wdata=load_data combinationally, and increment the load count at the edge.
REQ-023 LOAD SHALL exit to RUN after the accepted word with load_last=1 or the accepted word at index WORDS-1, whichever comes first; pc set to RESET_PC.
REQ-024 Outside LOAD: load_ready=0, mem_we=0; load_valid ignored.
REQ-025 In RUN: mem_raddr SHALL equal pc[31:2]; mem_waddr/mem_wdata SHALL be 0 when mem_we=0.
REQ-026 Advance condition is (!if_valid || if_ready) with no redirect: at the edge, if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^32).
REQ-027 First if_valid SHALL assert exactly one cycle after entering RUN (1-cycle fetch latency).
REQ-028 if_valid=1 with if_ready=0 SHALL hold if_instr, if_pc, pc unchanged.
REQ-029 redirect_valid in RUN SHALL take priority: at the edge if_valid<=0, pc<=redirect_pc; next fetch is from redirect_pc; redirect_valid outside RUN ignored.
REQ-030 redirect_pc[1:0]!=0 at a redirect SHALL enter FAULT.
REQ-031 A fetch with pc[31:2]>=WORDS SHALL enter FAULT instead of producing if_valid.
REQ-032 In FAULT: fault=1, if_valid=0, no fetch, no load; exits only via reset.

Reset
REQ-033 Reset SHALL act from any state, mid-load or mid-run, at the next rising edge.
REQ-034 Reset values: state=LOAD, load count=0, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fault=0, mem_we=0.
REQ-035 The block SHALL NOT clear memory contents; memory reset is the memory's own concern.

Structure
REQ-036 Shared package core_pkg SHALL hold fetch_state_t enum (LOAD, RUN, FAULT) and the default RESET_PC constant.
REQ-037 Load count width SHALL be $clog2(WORDS)+1 bits.
REQ-038 No sub-module; instruction memory is instantiated beside this block at core top level.

Verification
REQ-039 Load 3 words 0x00000013, 0x00100093, 0x00200113 (last on 3rd) -> mem_we on 3 cycles, waddr 0,1,2; RUN next cycle; if_valid one cycle later with if_pc=0, if_instr=0x00000013.
REQ-040 RUN with if_ready low 4 cycles after first fetch -> if_pc stays 0, mem_raddr stays 1; if_ready high -> if_pc 4 then 8.
REQ-041 redirect_valid=1, redirect_pc=0x8 while if_valid=1 -> if_valid=0 next cycle, then if_pc=0x8.
REQ-042 redirect_pc=0x6 -> fault=1, if_valid=0 held until reset; reset_n low one edge -> fault=0, state LOAD, load_ready=1.
REQ-043 WORDS=4, load 5 words without load_last -> only indices 0..3 written, RUN entered after 4th, load_ready=0 for 5th; fetch reaching pc=0x10 -> fault=1.
REQ-044 reset_n low during 2nd load word -> load count 0; next load word written at waddr 0.
